activation_stream: RTL and testbench
====================================

ACTIVATION_STREAM -- requirements
Module: activation_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement lane width (>=4).
REQ-002 SHALL have parameter LANES, default 4, number of parallel lanes per beat.
REQ-003 SHALL have parameter LEAK_SHIFT, default 3, arithmetic right-shift applied to negative lanes in leaky mode.
REQ-004 SHALL have parameter CLAMP_MAX, default 2**(DATA_WIDTH-1)-1, positive ceiling in clamped mode.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have ports mode_in (input, 2) and mode_valid (input, 1): requested activation mode and its strobe.
REQ-008 SHALL have ports s_tdata (input, LANES*DATA_WIDTH), s_tvalid (input, 1), s_tready (output, 1) and s_tlast (input, 1): input stream, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ports m_tdata (output, LANES*DATA_WIDTH), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1): output stream, same lane packing.
REQ-010 SHALL have ports active_mode (output, 2), the mode in force, and sat_count (output, 32), count of lanes clamped.

Function
REQ-011 Mode encoding SHALL be: 0 BYPASS (y=x), 1 RELU (y = x<0 ? 0 : x), 2 LEAKY (y = x<0 ? x>>>LEAK_SHIFT : x), 3 CLAMP (y = min(max(x,0),CLAMP_MAX)).
REQ-012 Sign SHALL be taken from bit DATA_WIDTH-1 of each lane; lanes SHALL be independent; output width SHALL equal input width with no overflow possible.
REQ-013 A beat SHALL be accepted when s_tvalid && s_tready; m_tdata/m_tlast for that beat SHALL be presented exactly 1 cycle later when the output is not stalled.
REQ-014 The block SHALL hold one output register plus one skid register; s_tready SHALL be registered and SHALL deassert only when the skid register is full.
REQ-015 While m_tvalid && !m_tready, m_tdata, m_tlast and m_tvalid SHALL be held stable.
REQ-016 No beat SHALL be dropped, duplicated or reordered under any tready pattern.
REQ-017 m_tlast SHALL equal the s_tlast of the corresponding beat.
REQ-018 Packet FSM SHALL have states IDLE (between packets) and IN_PKT; IDLE->IN_PKT on an accepted beat with s_tlast=0; IN_PKT->IDLE on an accepted beat with s_tlast=1; a single-beat packet (s_tlast=1 while IDLE) SHALL stay in IDLE.
REQ-019 mode_valid SHALL load a pending-mode register (last strobe wins); pending mode SHALL become active_mode only at a packet boundary: immediately if FSM is IDLE and no beat is accepted that cycle, otherwise on the cycle after the accepted s_tlast beat.
REQ-020 If mode_valid coincides with the accepted first beat of a packet while IDLE, the new mode SHALL apply to that beat.
REQ-021 A mode change SHALL never alter a beat already accepted.
REQ-022 sat_count SHALL increment by the number of lanes where CLAMP mode replaced x>CLAMP_MAX, per accepted beat, saturating at 2^32-1.

Reset
REQ-023 On rst: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, skid empty, FSM=IDLE, active_mode=1 (RELU), pending mode=1, sat_count=0.
REQ-024 s_tready SHALL rise the first cycle after rst deasserts.
REQ-025 rst mid-packet SHALL discard all in-flight beats and pending mode without emitting them.

Structure
REQ-026 Mode encodings (BYPASS, RELU, LEAKY, CLAMP) and FSM state codes SHALL live in the shared activation package/header.
REQ-027 Per-lane arithmetic SHALL be a combinational sub-module act_lane (DATA_WIDTH, LEAK_SHIFT, CLAMP_MAX, mode, x -> y, clamped flag), instantiated LANES times via generate.

Verification
REQ-028 RELU, LANES=4, W=16, in {0x7FFF,0x8000,0x0001,0xFFFF}, m_tready=1 -> one cycle later {0x7FFF,0x0000,0x0001,0x0000}.
REQ-029 LEAKY, LEAK_SHIFT=3, lane -64 (0xFFC0) and 40 -> -8 (0xFFF8) and 40; -1 -> -1 (0xFFFF).
REQ-030 CLAMP, CLAMP_MAX=1000, lanes {2000,500,-5,1000} -> {1000,500,0,1000}, sat_count +1.
REQ-031 Mode write RELU->BYPASS on beat 2 of a 4-beat packet -> beats 1-4 RELU, next packet BYPASS.
REQ-032 100-beat random stream, random m_tready (50%) and s_tvalid -> output order/data matches model; no beat lost; m_tdata stable while stalled.
REQ-033 rst asserted mid-packet with output stalled -> next cycle m_tvalid=0, s_tready=0, active_mode=RELU, sat_count=0.

Source files
------------

// File: rtl/activation_stream_pkg.sv
// activation_stream_pkg
//   Shared constants for the activation stream block.
//   - MODE_*  : 2-bit activation mode encodings carried on mode_in/active_mode.
//   - ST_*    : packet FSM state codes (IDLE between packets, IN_PKT inside one).
package activation_stream_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_CLAMP  = 2'd3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

endpackage

// File: rtl/activation_stream_act_lane.sv
// act_lane
//   Combinational activation for one signed two's-complement lane.
//   Ports:
//     mode    : activation mode (BYPASS / RELU / LEAKY / CLAMP)
//     x       : lane input
//     y       : lane output, same width as x
//     clamped : high when CLAMP mode replaced a value above CLAMP_MAX
module act_lane
  import activation_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 2**(DATA_WIDTH-1)-1
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  clamped
);

  localparam logic [DATA_WIDTH-1:0] CMAX = DATA_WIDTH'(CLAMP_MAX);

  logic                  neg;
  logic                  over;
  logic [DATA_WIDTH-1:0] leak;

  assign neg  = x[DATA_WIDTH-1];
  // Both operands are non-negative when neg is low, so an unsigned compare is exact.
  assign over = !neg && (x > CMAX);
  assign leak = $signed(x) >>> LEAK_SHIFT;

  always_comb begin
    y       = x;
    clamped = 1'b0;
    case (mode)
      MODE_BYPASS: y = x;
      MODE_RELU:   if (neg) y = '0;
      MODE_LEAKY:  if (neg) y = leak;
      MODE_CLAMP: begin
        if (neg) begin
          y = '0;
        end else if (over) begin
          y       = CMAX;
          clamped = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/activation_stream.sv
// activation_stream
//   Streaming per-lane activation (bypass / relu / leaky / clamp) with a
//   one-register output stage plus a skid register, so s_tready can be
//   registered without losing beats.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     mode_in, mode_valid           : requested mode and its strobe
//     s_tdata/s_tvalid/s_tready/s_tlast : input stream, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//     m_tdata/m_tvalid/m_tready/m_tlast : output stream, same packing
//     active_mode                   : mode applied to beats of the current packet
//     sat_count                     : saturating count of lanes clamped to CLAMP_MAX
module activation_stream
  import activation_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 2**(DATA_WIDTH-1)-1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode_in,
  input  logic                        mode_valid,
  input  logic [LANES*DATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic                        s_tlast,
  output logic [LANES*DATA_WIDTH-1:0] m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic [1:0]                  active_mode,
  output logic [31:0]                 sat_count
);

  localparam int BW = LANES*DATA_WIDTH;

  logic [0:0]       state;
  logic [1:0]       pending_mode;
  logic [1:0]       pending_next;
  logic [1:0]       beat_mode;
  logic             accept;
  logic             out_free;
  logic [BW-1:0]    act_data;
  logic [LANES-1:0] lane_clamped;
  logic [BW-1:0]    skid_data;
  logic             skid_valid;
  logic             skid_last;
  logic [31:0]      clamp_cnt;
  logic [32:0]      sat_sum;

  assign accept       = s_tvalid && s_tready;
  assign out_free     = !m_tvalid || m_tready;
  assign pending_next = mode_valid ? mode_in : pending_mode;
  // Between packets the freshest requested mode applies, so a strobe that
  // arrives with the first beat of a packet already governs that beat.
  assign beat_mode    = (state == ST_IDLE) ? pending_next : active_mode;

  // The activation is applied at acceptance time, so later mode changes
  // cannot touch beats already sitting in the output or skid register.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CLAMP_MAX (CLAMP_MAX)
    ) u_lane (
      .mode   (beat_mode),
      .x      (s_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .y      (act_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .clamped(lane_clamped[i])
    );
  end

  always_comb begin
    clamp_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      clamp_cnt = clamp_cnt + 32'(lane_clamped[i]);
    end
  end

  assign sat_sum = {1'b0, sat_count} + {1'b0, clamp_cnt};

  // Output register plus skid register. s_tready mirrors "skid empty" one
  // cycle ahead, so a beat can only be accepted when there is room for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      s_tready   <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        m_tvalid   <= 1'b1;
        m_tdata    <= skid_data;
        m_tlast    <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        m_tvalid <= accept;
        if (accept) begin
          m_tdata <= act_data;
          m_tlast <= s_tlast;
        end
      end
      s_tready <= 1'b1;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= act_data;
      skid_last  <= s_tlast;
      s_tready   <= 1'b0;
    end else begin
      s_tready <= !skid_valid;
    end
  end

  // Packet FSM and mode hand-over: active_mode tracks the pending mode while
  // idle and is frozen from the first beat until the last beat of a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pending_mode <= MODE_RELU;
      active_mode  <= MODE_RELU;
      sat_count    <= '0;
    end else begin
      pending_mode <= pending_next;
      if (state == ST_IDLE) begin
        active_mode <= pending_next;
        if (accept && !s_tlast) state <= ST_IN_PKT;
      end else if (accept && s_tlast) begin
        active_mode <= pending_next;
        state       <= ST_IDLE;
      end
      if (accept) sat_count <= sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

endmodule

// File: tb/tb_activation_stream.sv
// tb_activation_stream
//   Directed checks of reset, each activation mode, mode hand-over at packet
//   boundaries, a randomised back-pressure stream against a reference model,
//   and reset in the middle of a stalled packet.
module tb_activation_stream;

  localparam int W  = 16;
  localparam int L  = 4;
  localparam int BW = W*L;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode_in;
  logic          mode_valid;
  logic [BW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [1:0]    active_mode;
  logic [31:0]   sat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int sat_exp = 0;

  always #5 clk = ~clk;

  activation_stream #(
    .DATA_WIDTH(W),
    .LANES     (L),
    .LEAK_SHIFT(3),
    .CLAMP_MAX (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_in    (mode_in),
    .mode_valid (mode_valid),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .active_mode(active_mode),
    .sat_count  (sat_count)
  );

  function automatic logic [15:0] act_ref(input logic [1:0] mode, input logic [15:0] x);
    logic signed [15:0] sx;
    sx = x;
    case (mode)
      2'd0:    return x;
      2'd1:    return x[15] ? 16'h0000 : x;
      2'd2:    return x[15] ? 16'(sx >>> 3) : x;
      default: return x[15] ? 16'h0000 : ((x > 16'd1000) ? 16'd1000 : x);
    endcase
  endfunction

  function automatic logic [63:0] act_beat(input logic [1:0] mode, input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = act_ref(mode, d[i*16 +: 16]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_in    = m;
    mode_valid = 1'b1;
    s_tvalid   = 1'b0;
    step();
    mode_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 64'h0) begin n_bad++; $display("[TB] FAIL reset_m_tdata: got %h want 0", m_tdata); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_m_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_s_tready: got %b want 0", s_tready); end
    n_cmp++; if (active_mode !== 2'd1) begin n_bad++; $display("[TB] FAIL reset_active_mode: got %0d want 1", active_mode); end
    n_cmp++; if (sat_count !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_sat_count: got %0d want 0", sat_count); end
    rst = 1'b0;
    step();
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("[TB] FAIL ready_after_reset: got %b want 1", s_tready); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_m_tvalid: got %b want 0", m_tvalid); end
  endtask

  task automatic test_relu();
    m_tready = 1'b1;
    s_tdata  = 64'hFFFF_0001_8000_7FFF;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("[TB] FAIL relu_valid: got %b want 1", m_tvalid); end
    n_cmp++; if (m_tdata !== 64'h0000_0001_0000_7FFF) begin n_bad++; $display("[TB] FAIL relu_data: got %h want %h", m_tdata, 64'h0000_0001_0000_7FFF); end
    n_cmp++; if (m_tlast !== 1'b1) begin n_bad++; $display("[TB] FAIL relu_last: got %b want 1", m_tlast); end
    step();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL relu_drain: got %b want 0", m_tvalid); end
  endtask

  task automatic test_leaky();
    set_mode(2'd2);
    n_cmp++; if (active_mode !== 2'd2) begin n_bad++; $display("[TB] FAIL leaky_mode: got %0d want 2", active_mode); end
    s_tdata  = 64'h0000_FFFF_0028_FFC0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    n_cmp++; if (m_tdata !== 64'h0000_FFFF_0028_FFF8) begin n_bad++; $display("[TB] FAIL leaky_data: got %h want %h", m_tdata, 64'h0000_FFFF_0028_FFF8); end
    n_cmp++; if (sat_count !== 32'd0) begin n_bad++; $display("[TB] FAIL leaky_sat: got %0d want 0", sat_count); end
  endtask

  task automatic test_clamp();
    set_mode(2'd3);
    s_tdata  = 64'h03E8_FFFB_01F4_07D0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    n_cmp++; if (m_tdata !== 64'h03E8_0000_01F4_03E8) begin n_bad++; $display("[TB] FAIL clamp_data1: got %h want %h", m_tdata, 64'h03E8_0000_01F4_03E8); end
    n_cmp++; if (sat_count !== 32'd1) begin n_bad++; $display("[TB] FAIL clamp_sat1: got %0d want 1", sat_count); end
    s_tdata = 64'h8000_0000_03E9_7FFF;
    step();
    s_tvalid = 1'b0;
    n_cmp++; if (m_tdata !== 64'h0000_0000_03E8_03E8) begin n_bad++; $display("[TB] FAIL clamp_data2: got %h want %h", m_tdata, 64'h0000_0000_03E8_03E8); end
    n_cmp++; if (sat_count !== 32'd3) begin n_bad++; $display("[TB] FAIL clamp_sat2: got %0d want 3", sat_count); end
    sat_exp = 3;
  endtask

  task automatic test_mode_switch();
    logic [63:0] beats [4];
    logic [63:0] relu_exp [4];
    beats[0] = 64'h1234_8000_0005_FFF0; relu_exp[0] = 64'h1234_0000_0005_0000;
    beats[1] = 64'hFFFF_0100_F000_0042; relu_exp[1] = 64'h0000_0100_0000_0042;
    beats[2] = 64'h7FFF_FFFE_0001_8001; relu_exp[2] = 64'h7FFF_0000_0001_0000;
    beats[3] = 64'h0003_C000_4000_FFFF; relu_exp[3] = 64'h0003_0000_4000_0000;
    set_mode(2'd1);
    n_cmp++; if (active_mode !== 2'd1) begin n_bad++; $display("[TB] FAIL switch_start_mode: got %0d want 1", active_mode); end
    for (int i = 0; i < 4; i++) begin
      s_tdata    = beats[i];
      s_tlast    = (i == 3);
      s_tvalid   = 1'b1;
      mode_in    = 2'd0;
      mode_valid = (i == 1);
      step();
      mode_valid = 1'b0;
      n_cmp++; if (m_tdata !== relu_exp[i]) begin n_bad++; $display("[TB] FAIL switch_beat%0d: got %h want %h", i, m_tdata, relu_exp[i]); end
      n_cmp++; if (m_tlast !== (i == 3)) begin n_bad++; $display("[TB] FAIL switch_last%0d: got %b want %b", i, m_tlast, (i == 3)); end
      if (i == 1) begin
        n_cmp++; if (active_mode !== 2'd1) begin n_bad++; $display("[TB] FAIL switch_mid_mode: got %0d want 1", active_mode); end
      end
    end
    s_tvalid = 1'b0;
    n_cmp++; if (active_mode !== 2'd0) begin n_bad++; $display("[TB] FAIL switch_end_mode: got %0d want 0", active_mode); end
    s_tdata  = 64'h1234_8000_0005_FFF0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    n_cmp++; if (m_tdata !== 64'h1234_8000_0005_FFF0) begin n_bad++; $display("[TB] FAIL switch_bypass: got %h want %h", m_tdata, 64'h1234_8000_0005_FFF0); end
    s_tdata    = 64'h0000_0000_0028_FFC0;
    s_tlast    = 1'b1;
    s_tvalid   = 1'b1;
    mode_in    = 2'd2;
    mode_valid = 1'b1;
    step();
    s_tvalid   = 1'b0;
    mode_valid = 1'b0;
    n_cmp++; if (m_tdata !== 64'h0000_0000_0028_FFF8) begin n_bad++; $display("[TB] FAIL first_beat_mode: got %h want %h", m_tdata, 64'h0000_0000_0028_FFF8); end
    n_cmp++; if (active_mode !== 2'd2) begin n_bad++; $display("[TB] FAIL first_beat_active: got %0d want 2", active_mode); end
  endtask

  task automatic test_stream();
    logic [64:0] exp_q [$];
    logic [64:0] e;
    logic [63:0] held;
    logic        held_last;
    logic        stalled;
    logic        pend;
    int          sent;
    int          recv;
    int          cyc;
    set_mode(2'd3);
    stalled = 1'b0;
    pend    = 1'b0;
    sent    = 0;
    recv    = 0;
    cyc     = 0;
    held    = '0;
    held_last = 1'b0;
    while ((sent < 100 || recv < 100) && cyc < 3000) begin
      @(posedge clk);
      #1;
      if (!pend) begin
        if (sent < 100 && $urandom_range(0, 3) != 0) begin
          s_tvalid = 1'b1;
          s_tdata  = {$urandom, $urandom};
          s_tlast  = ($urandom_range(0, 3) == 0) || (sent == 99);
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== held || m_tlast !== held_last) begin
          n_bad++; $display("[TB] FAIL stall_hold: got v=%b %h l=%b want v=1 %h l=%b", m_tvalid, m_tdata, m_tlast, held, held_last);
        end
      end
      if (m_tvalid && m_tready) begin
        recv++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("[TB] FAIL stream_extra: got %h want no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e[63:0] || m_tlast !== e[64]) begin
            n_bad++; $display("[TB] FAIL stream_beat%0d: got %h l=%b want %h l=%b", recv, m_tdata, m_tlast, e[63:0], e[64]);
          end
        end
      end
      if (s_tvalid && s_tready) begin
        exp_q.push_back({s_tlast, act_beat(2'd3, s_tdata)});
        for (int i = 0; i < 4; i++) begin
          if (!s_tdata[i*16+15] && s_tdata[i*16 +: 16] > 16'd1000) sat_exp++;
        end
        sent++;
        pend = 1'b0;
      end else begin
        pend = s_tvalid;
      end
      stalled   = m_tvalid && !m_tready;
      held      = m_tdata;
      held_last = m_tlast;
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    n_cmp++; if (sent != 100 || recv != 100 || exp_q.size() != 0) begin
      n_bad++; $display("[TB] FAIL stream_count: got sent=%0d recv=%0d left=%0d want 100/100/0", sent, recv, exp_q.size());
    end
    n_cmp++; if (sat_count !== 32'(sat_exp)) begin n_bad++; $display("[TB] FAIL stream_sat: got %0d want %0d", sat_count, sat_exp); end
  endtask

  task automatic test_reset_mid_packet();
    m_tready = 1'b0;
    s_tdata  = 64'h0001_0002_0003_0004;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    step();
    s_tdata    = 64'h0005_0006_0007_0008;
    mode_in    = 2'd0;
    mode_valid = 1'b1;
    step();
    mode_valid = 1'b0;
    s_tvalid   = 1'b0;
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("[TB] FAIL skid_full_ready: got %b want 0", s_tready); end
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h0001_0002_0003_0004) begin
      n_bad++; $display("[TB] FAIL stalled_out: got v=%b %h want v=1 %h", m_tvalid, m_tdata, 64'h0001_0002_0003_0004);
    end
    rst = 1'b1;
    step();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_valid: got %b want 0", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_ready: got %b want 0", s_tready); end
    n_cmp++; if (active_mode !== 2'd1) begin n_bad++; $display("[TB] FAIL midrst_mode: got %0d want 1", active_mode); end
    n_cmp++; if (sat_count !== 32'd0) begin n_bad++; $display("[TB] FAIL midrst_sat: got %0d want 0", sat_count); end
    rst      = 1'b0;
    m_tready = 1'b1;
    step();
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("[TB] FAIL postrst_ready: got %b want 1", s_tready); end
    step();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL postrst_no_emit: got %b want 0", m_tvalid); end
    s_tdata  = 64'hFFFF_0010_8000_0020;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    n_cmp++; if (m_tdata !== 64'h0000_0010_0000_0020) begin n_bad++; $display("[TB] FAIL postrst_relu: got %h want %h", m_tdata, 64'h0000_0010_0000_0020); end
  endtask

  initial begin
    rst        = 1'b1;
    mode_in    = 2'd0;
    mode_valid = 1'b0;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    m_tready   = 1'b1;
    test_reset();
    test_relu();
    test_leaky();
    test_clamp();
    test_mode_switch();
    test_stream();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
